// File: rtl/bpu_update_sched_pkg.sv
// Shared types for the branch predictor update scheduler: widths, state codes
// and the packed update record that travels through the update FIFO.
package bpu_update_sched_pkg;

  localparam int RegW   = 32;
  localparam int BtbLen = 6;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Packed as {taken, target, pc} so the FIFO only sees a flat vector
  typedef struct packed {
    logic            taken;
    logic [RegW-1:0] target;
    logic [RegW-1:0] pc;
  } upd_rec_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small synchronous FIFO holding pending predictor updates.
// Push when full and pop when empty are ignored.
module bpu_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PtrW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PtrW+1)'(1);
        2'b01:   count <= count - (PtrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bpu_update_sched.sv
// Merges ID and EX resolved-branch records into the single predictor update
// port and runs the table-clear walk after reset and on reinit requests.
module bpu_update_sched
  import bpu_update_sched_pkg::*;
#(
  parameter int BTB_LEN = BtbLen,
  parameter int DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reinit_i,
  input  logic               ex_upd_valid_i,
  output logic               ex_upd_ready_o,
  input  logic [RegW-1:0]    ex_upd_pc_i,
  input  logic [RegW-1:0]    ex_upd_target_i,
  input  logic               ex_upd_taken_i,
  input  logic               id_upd_valid_i,
  output logic               id_upd_ready_o,
  input  logic [RegW-1:0]    id_upd_pc_i,
  input  logic [RegW-1:0]    id_upd_target_i,
  input  logic               id_upd_taken_i,
  output logic               pd_upd_valid_o,
  output logic [RegW-1:0]    pd_upd_pc_o,
  output logic [RegW-1:0]    pd_upd_target_o,
  output logic               pd_upd_taken_o,
  output logic               pd_init_o,
  output logic [BTB_LEN-1:0] pd_init_idx_o,
  output logic               init_done_o,
  output logic               busy_o
);

  sched_state_e       state_q;
  sched_state_e       state_d;
  logic [BTB_LEN-1:0] idx_q;

  logic     fifo_full;
  logic     fifo_empty;
  logic     push_ex;
  logic     push_id;
  logic     push;
  upd_rec_t wr_rec;
  upd_rec_t head;
  logic [$bits(upd_rec_t)-1:0] fifo_rdata;

  // EX is the older instruction so it always wins; ID only goes when EX is idle
  assign ex_upd_ready_o = (state_q == RUN) & ~fifo_full;
  assign id_upd_ready_o = (state_q == RUN) & ~fifo_full & ~ex_upd_valid_i;
  assign push_ex        = ex_upd_valid_i & ex_upd_ready_o;
  assign push_id        = id_upd_valid_i & id_upd_ready_o;
  assign push           = push_ex | push_id;

  always_comb begin
    wr_rec = '0;
    if (push_ex) begin
      wr_rec.taken  = ex_upd_taken_i;
      wr_rec.target = ex_upd_target_i;
      wr_rec.pc     = ex_upd_pc_i;
    end else begin
      wr_rec.taken  = id_upd_taken_i;
      wr_rec.target = id_upd_target_i;
      wr_rec.pc     = id_upd_pc_i;
    end
  end

  bpu_upd_fifo #(
    .WIDTH ($bits(upd_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pd_upd_valid_o),
    .wdata  (wr_rec),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head = upd_rec_t'(fifo_rdata);

  // Fields are gated so the predictor sees zeros whenever nothing is issued
  assign pd_upd_valid_o  = ~fifo_empty & ((state_q == RUN) | (state_q == DRAIN));
  assign pd_upd_pc_o     = pd_upd_valid_o ? head.pc     : '0;
  assign pd_upd_target_o = pd_upd_valid_o ? head.target : '0;
  assign pd_upd_taken_o  = pd_upd_valid_o ? head.taken  : 1'b0;

  // Qualified by rst_ni so the clear strobe stays low while reset is held
  assign pd_init_o     = (state_q == INIT) & rst_ni;
  assign pd_init_idx_o = idx_q;
  assign init_done_o   = (state_q == RUN);
  assign busy_o        = (state_q != RUN) | ~fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (&idx_q) state_d = RUN;
      RUN:     if (reinit_i) state_d = (fifo_empty && !push) ? INIT : DRAIN;
      DRAIN:   if (fifo_empty) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) idx_q <= idx_q + BTB_LEN'(1);
      else                 idx_q <= '0;
    end
  end

endmodule
